// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the fetch/data memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

   // Width of the fetch starvation counter; holds STARVE_LIM up to 15.
   localparam int STARVE_W = 4;

   // Arbiter sequencing states, explicitly 2 bits wide.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_IF_BUSY = 2'd1,
      ST_D_BUSY  = 2'd2,
      ST_RESP    = 2'd3
   } arb_state_t;

   // Byte-enable pattern used for every instruction fetch (full word).
   localparam logic [3:0] C_BE_WORD = 4'hF;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_prio.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_prio
// Brief    : Data-first grant decision with a fetch anti-starvation counter.
//            The counter counts data grants made while a fetch is waiting
//            and forces a fetch grant once it reaches STARVE_LIM.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIM = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic if_req,
   input  logic d_req,
   input  logic grant_stb,
   output logic grant_if,
   output logic grant_d
);

   localparam logic [STARVE_W-1:0] C_LIM = STARVE_LIM[STARVE_W-1:0];

   logic [STARVE_W-1:0] r_starve_cnt;
   logic                w_starved;

   // Fetch has waited long enough once the counter reaches the limit.
   assign w_starved = (r_starve_cnt == C_LIM);

   // Data wins ties unless fetch is starved; a lone requester always wins.
   assign grant_d  = d_req  & (~if_req | ~w_starved);
   assign grant_if = if_req & (~d_req  |  w_starved);

   // Starvation counter: cleared by fetch grants, bumped by data grants
   // that bypass a waiting fetch, saturating at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt <= '0;
      end else if (grant_stb) begin
         if (grant_if) begin
            r_starve_cnt <= '0;
         end else if (grant_d && if_req && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
         end
      end
   end

endmodule : mem_arb_prio
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb
// Brief    : Single-port memory arbiter and access sequencer shared by the
//            instruction fetch and load/store stages. Grants one requester at
//            a time, holds the memory request until ack, returns a one-cycle
//            response pulse and discards fetches cancelled by a redirect.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIM = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   // instruction fetch side
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_kill,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic        if_stall,
   // load/store side
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_valid,
   output logic [31:0] d_rdata,
   output logic        d_stall,
   // shared memory port
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   arb_state_t  r_state;
   arb_state_t  w_state_nxt;
   logic        r_drop;
   logic        w_drop_nxt;
   logic        r_owner_d;
   logic        w_load_if;
   logic        w_load_d;
   logic        w_done;
   logic        w_if_stale;
   logic        w_grant_if;
   logic        w_grant_d;
   logic        w_grant_stb;

   logic        r_mem_req;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [3:0]  r_mem_be;
   logic [31:0] r_if_inst;
   logic [31:0] r_d_rdata;

   // Grant decisions are only taken while idle.
   assign w_grant_stb = (r_state == ST_IDLE);

   mem_arb_prio #(
      .STARVE_LIM (STARVE_LIM)
   ) u_prio (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .d_req     (d_req),
      .grant_stb (w_grant_stb),
      .grant_if  (w_grant_if),
      .grant_d   (w_grant_d)
   );

   // A fetch is stale if a redirect was seen earlier or arrives this cycle.
   assign w_if_stale = r_drop | if_kill;

   // State register and drop flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_drop  <= w_drop_nxt;
      end
   end

   // Next-state logic, grant loading and access completion.
   always_comb begin
      w_state_nxt = r_state;
      w_drop_nxt  = r_drop;
      w_load_if   = 1'b0;
      w_load_d    = 1'b0;
      w_done      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_drop_nxt = 1'b0;
            if (w_grant_d) begin
               w_load_d    = 1'b1;
               w_state_nxt = ST_D_BUSY;
            end else if (w_grant_if) begin
               w_load_if   = 1'b1;
               w_state_nxt = ST_IF_BUSY;
            end
         end
         ST_IF_BUSY: begin
            if (if_kill) begin
               w_drop_nxt = 1'b1;
            end
            if (mem_ack) begin
               w_done = 1'b1;
               if (w_if_stale) begin
                  // cancelled fetch: swallow the response
                  w_drop_nxt  = 1'b0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_RESP;
               end
            end
         end
         ST_D_BUSY: begin
            if (mem_ack) begin
               w_done      = 1'b1;
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Registered memory request: loaded from the winner, held until ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
         r_owner_d   <= 1'b0;
      end else if (w_load_d) begin
         r_mem_req   <= 1'b1;
         r_mem_we    <= d_we;
         r_mem_addr  <= d_addr;
         r_mem_wdata <= d_wdata;
         r_mem_be    <= d_be;
         r_owner_d   <= 1'b1;
      end else if (w_load_if) begin
         r_mem_req   <= 1'b1;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= if_addr;
         r_mem_wdata <= '0;
         r_mem_be    <= C_BE_WORD;
         r_owner_d   <= 1'b0;
      end else if (w_done) begin
         r_mem_req   <= 1'b0;
      end
   end

   // Response data capture: fetch words unless stale, load data on loads only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_if_inst <= '0;
         r_d_rdata <= '0;
      end else if (w_done) begin
         if (r_state == ST_IF_BUSY && !w_if_stale) begin
            r_if_inst <= mem_rdata;
         end
         if (r_state == ST_D_BUSY && !r_mem_we) begin
            r_d_rdata <= mem_rdata;
         end
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_be    = r_mem_be;
   assign if_inst   = r_if_inst;
   assign d_rdata   = r_d_rdata;

   // Response pulses; a redirect in the response cycle suppresses the fetch.
   assign if_valid = (r_state == ST_RESP) & ~r_owner_d & ~if_kill;
   assign d_valid  = (r_state == ST_RESP) &  r_owner_d;

   assign if_stall = if_req & ~if_valid;
   assign d_stall  = d_req  & ~d_valid;

endmodule : mem_arb
`default_nettype wire
